// File: rtl/conv_encoder_12_4.sv
// Rate-1/2 K=3 (7,5 octal) zero-tail convolutional encoder for 4-bit messages.
// Serial symbol pairs and a 12-bit parallel codeword; define ENC_SELFCHECK_EN for a table-based self-check.
module conv_encoder_12_4 (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [1:0]  sym_out,
  output logic        sym_valid,
  output logic [11:0] codeword,
  output logic        cw_valid,
  output logic        cw_err
);

  typedef enum logic [1:0] {IDLE, ENC, FLUSH} state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  cnt;
  logic        s1;
  logic        s0;
  logic [9:0]  acc;
  logic [3:0]  msg;
  logic        u;
  logic        c0;
  logic        c1;
  logic        accept;
  logic        last;
  logic [11:0] cw_full;

  assign data_ready = (state == IDLE) && !rst;
  assign accept     = data_valid && data_ready;
  // Message is sent MSB first; the flush cycles shift in the two zero tail bits.
  assign u          = (state == ENC) ? msg[2'd3 - cnt[1:0]] : 1'b0;
  assign c0         = u ^ s1 ^ s0;
  assign c1         = u ^ s0;
  assign last       = (state == FLUSH) && (cnt == 3'd5);
  assign cw_full    = {acc, c0, c1};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ENC;
      ENC:     if (cnt == 3'd3) state_next = FLUSH;
      FLUSH:   if (cnt == 3'd5) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msg       <= '0;
      cnt       <= '0;
      s1        <= 1'b0;
      s0        <= 1'b0;
      acc       <= '0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
      codeword  <= '0;
      cw_valid  <= 1'b0;
    end else begin
      sym_valid <= 1'b0;
      cw_valid  <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          msg <= data_in;
          s1  <= 1'b0;
          s0  <= 1'b0;
          acc <= '0;
          cnt <= '0;
        end
      end else begin
        sym_out   <= {c0, c1};
        sym_valid <= 1'b1;
        acc       <= {acc[7:0], c0, c1};
        s1        <= u;
        s0        <= s1;
        cnt       <= cnt + 3'd1;
        if (last) begin
          codeword <= cw_full;
          cw_valid <= 1'b1;
        end
      end
    end
  end

`ifdef ENC_SELFCHECK_EN
  // Each entry is the XOR of the generator rows selected by the message bits.
  localparam logic [11:0] CW_TABLE [16] = '{
    12'h000, 12'h03B, 12'h0EC, 12'h0D7,
    12'h3B0, 12'h38B, 12'h35C, 12'h367,
    12'hEC0, 12'hEFB, 12'hE2C, 12'hE17,
    12'hD70, 12'hD4B, 12'hD9C, 12'hDA7
  };

  always_ff @(posedge clk) begin
    if (rst) cw_err <= 1'b0;
    else     cw_err <= last && (cw_full != CW_TABLE[msg]);
  end
`else
  assign cw_err = 1'b0;
`endif

endmodule

// File: tb/tb_conv_encoder_12_4.sv
// Self-checking bench for conv_encoder_12_4: known-vector table, random messages
// against a convolution model, streaming, busy and mid-stream reset sequences.
module tb_conv_encoder_12_4;

  logic        clk;
  logic        rst;
  logic [3:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic [1:0]  sym_out;
  logic        sym_valid;
  logic [11:0] codeword;
  logic        cw_valid;
  logic        cw_err;

  int total;
  int bad;

  typedef struct {
    logic [3:0]  msg;
    logic [11:0] cw;
  } vec_t;

  vec_t vecs[16];

  conv_encoder_12_4 dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .sym_out    (sym_out),
    .sym_valid  (sym_valid),
    .codeword   (codeword),
    .cw_valid   (cw_valid),
    .cw_err     (cw_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [11:0] actual, input logic [11:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Reference: zero-tail convolution with generators 111 and 101 over the padded bit stream.
  function automatic logic [11:0] modelCodeword(input logic [3:0] m);
    logic [11:0] r;
    int ub[8];
    int c0;
    int c1;
    ub[0] = 0; ub[1] = 0;
    ub[2] = m[3]; ub[3] = m[2]; ub[4] = m[1]; ub[5] = m[0];
    ub[6] = 0; ub[7] = 0;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      c0 = (ub[i+2] + ub[i+1] + ub[i]) % 2;
      c1 = (ub[i+2] + ub[i]) % 2;
      r[11-2*i]   = c0[0];
      r[10-2*i]   = c1[0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_sym_valid"}, 12'(sym_valid), 12'd0);
    checkOutput({tag, "_cw_valid"}, 12'(cw_valid), 12'd0);
    checkOutput({tag, "_cw_err"}, 12'(cw_err), 12'd0);
  endtask

  // Send one message from idle and check every symbol, the strobe timing and the codeword.
  task automatic applyStimulus(input logic [3:0] m, input logic [11:0] exp_cw);
    logic [3:0] junk;
    checkOutput("ready_before_accept", 12'(data_ready), 12'd1);
    data_in    = m;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    junk       = 4'($urandom_range(0, 15));
    data_in    = junk;
    checkOutput("ready_after_accept", 12'(data_ready), 12'd0);
    checkOutput("sym_valid_e0", 12'(sym_valid), 12'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("sym_valid", 12'(sym_valid), 12'd1);
      checkOutput("sym_out", 12'(sym_out), 12'(exp_cw[11-2*i -: 2]));
      checkOutput("cw_valid_timing", 12'(cw_valid), (i == 5) ? 12'd1 : 12'd0);
      checkOutput("ready_busy", 12'(data_ready), (i == 5) ? 12'd1 : 12'd0);
    end
    checkOutput("codeword", codeword, exp_cw);
    checkOutput("cw_err", 12'(cw_err), 12'd0);
    tick();
    checkIdleOutputs("after_cw");
    checkOutput("codeword_hold", codeword, exp_cw);
  endtask

  initial begin
    logic [3:0]  rm;
    logic [3:0]  smsgs[3];
    logic [11:0] sexp[3];
    int          acc_cyc[$];
    logic [11:0] got[$];
    int          idx;

    total = 0;
    bad   = 0;

    vecs[0]  = '{4'h0, 12'h000}; vecs[1]  = '{4'h1, 12'h03B};
    vecs[2]  = '{4'h2, 12'h0EC}; vecs[3]  = '{4'h3, 12'h0D7};
    vecs[4]  = '{4'h4, 12'h3B0}; vecs[5]  = '{4'h5, 12'h38B};
    vecs[6]  = '{4'h6, 12'h35C}; vecs[7]  = '{4'h7, 12'h367};
    vecs[8]  = '{4'h8, 12'hEC0}; vecs[9]  = '{4'h9, 12'hEFB};
    vecs[10] = '{4'hA, 12'hE2C}; vecs[11] = '{4'hB, 12'hE17};
    vecs[12] = '{4'hC, 12'hD70}; vecs[13] = '{4'hD, 12'hD4B};
    vecs[14] = '{4'hE, 12'hD9C}; vecs[15] = '{4'hF, 12'hDA7};

    rst        = 1'b1;
    data_in    = 4'h0;
    data_valid = 1'b0;

    $display("[TB] reset");
    repeat (3) tick();
    checkOutput("rst_ready", 12'(data_ready), 12'd0);
    checkOutput("rst_sym_out", 12'(sym_out), 12'd0);
    checkOutput("rst_codeword", codeword, 12'd0);
    checkIdleOutputs("rst");
    rst = 1'b0;
    #1;
    checkOutput("ready_after_rst", 12'(data_ready), 12'd1);

    $display("[TB] impulse and all-ones");
    applyStimulus(4'b1000, 12'b111011000000);
    applyStimulus(4'b1111, 12'b110110100111);

    $display("[TB] exhaustive table");
    for (int v = 0; v < 16; v++) applyStimulus(vecs[v].msg, vecs[v].cw);

    $display("[TB] random messages against model");
    for (int n = 0; n < 20; n++) begin
      rm = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) tick();
      applyStimulus(rm, modelCodeword(rm));
    end

    $display("[TB] streaming");
    smsgs[0] = 4'd3; smsgs[1] = 4'd5; smsgs[2] = 4'd9;
    sexp[0]  = 12'b000011010111; sexp[1] = 12'b001110001011; sexp[2] = 12'b111011111011;
    idx        = 0;
    data_in    = smsgs[0];
    data_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (data_valid && data_ready) begin
        acc_cyc.push_back(c);
        idx++;
      end
      tick();
      if (idx < 3) data_in = smsgs[idx];
      else         data_valid = 1'b0;
      if (cw_valid) got.push_back(codeword);
    end
    checkOutput("stream_accepts", 12'(acc_cyc.size()), 12'd3);
    checkOutput("stream_cw_count", 12'(got.size()), 12'd3);
    if (acc_cyc.size() == 3) begin
      checkOutput("stream_gap1", 12'(acc_cyc[1] - acc_cyc[0]), 12'd7);
      checkOutput("stream_gap2", 12'(acc_cyc[2] - acc_cyc[1]), 12'd7);
    end
    for (int k = 0; k < 3; k++) begin
      if (k < got.size()) checkOutput("stream_codeword", got[k], sexp[k]);
    end

    $display("[TB] busy and mid-stream reset");
    tick();
    data_in    = 4'd9;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tick();
      data_valid = (k == 1);
      data_in    = 4'($urandom_range(0, 15));
      checkOutput("busy_ready", 12'(data_ready), 12'd0);
      checkOutput("busy_sym_valid", 12'(sym_valid), 12'd1);
    end
    rst        = 1'b1;
    data_valid = 1'b1;
    #1;
    checkOutput("abort_ready_in_rst", 12'(data_ready), 12'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("abort_ready", 12'(data_ready), 12'd0);
      checkOutput("abort_sym_out", 12'(sym_out), 12'd0);
      checkOutput("abort_codeword", codeword, 12'd0);
      checkIdleOutputs("abort");
    end
    rst        = 1'b0;
    data_valid = 1'b0;
    #1;
    checkOutput("ready_after_abort", 12'(data_ready), 12'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkIdleOutputs("post_abort");
    end
    applyStimulus(4'd6, 12'b001101011100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
